// File: rtl/uart_pkg.sv
// Shared definitions for the Uart transmit scheduler: Uart register map,
// control/status bit positions and the scheduler state encoding.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'b00;
   localparam logic [1:0] REG_STATUS = 2'b01;
   localparam logic [1:0] REG_CTRL   = 2'b10;

   localparam int STATUS_TX_BUSY = 0;
   localparam int CTRL_TX_START  = 0;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      SETTLE,
      POLL,
      DONE
   } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rrPtr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rrPtr,
   output logic [IDX_W-1:0]   gntIdx,
   output logic               gntValid
);

   int idx;

   always_comb begin
      gntIdx   = '0;
      gntValid = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rrPtr) + i) % NUM_REQ;
         if (!gntValid && req[idx]) begin
            gntValid = 1'b1;
            gntIdx   = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one Uart transmitter between NUM_REQ byte requesters.
// Optional POLL timeout with sticky timeoutErr is enabled by defining UART_SCHED_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | arbitrate; latch granted index and byte
//  LOAD   | write latched byte to Uart DATA
//  START  | write txStart to Uart CTRL
//  SETTLE | one idle cycle for txBusy to rise
//  POLL   | read STATUS until txBusy clears (or timeout)
//  DONE   | pulse ack for the grant, advance round-robin pointer
module uart_tx_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] reqData,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 busy,
   output logic                 writeEnable,
   output logic                 readEnable,
   output logic [1:0]           regSelect,
   output logic [7:0]           writeData,
   input  logic [7:0]           Data,
   output logic                 timeoutErr
);

   import uart_pkg::*;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t       state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic [7:0]         byte_q, byte_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               we_q, we_d;
   logic               re_q, re_d;
   logic [1:0]         sel_q, sel_d;
   logic [7:0]         wdat_q, wdat_d;
   logic               terr_q, terr_d;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic               unused_data;

   assign unused_data = ^Data;

`ifdef UART_SCHED_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req      (req),
      .rrPtr    (rr_ptr_q),
      .gntIdx   (arb_idx),
      .gntValid (arb_valid)
   );

   // Strobes are computed for the state being entered so they are registered
   // and line up with the cycle that state is held.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      byte_d   = byte_q;
      ack_d    = '0;
      we_d     = 1'b0;
      re_d     = 1'b0;
      sel_d    = REG_DATA;
      wdat_d   = '0;
      terr_d   = terr_q;
`ifdef UART_SCHED_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_idx;
               byte_d  = reqData[{arb_idx, 3'b000} +: 8];
               wdat_d  = reqData[{arb_idx, 3'b000} +: 8];
               we_d    = 1'b1;
               sel_d   = REG_DATA;
               state_d = LOAD;
            end
         end
         LOAD: begin
            we_d    = 1'b1;
            sel_d   = REG_CTRL;
            wdat_d  = 8'(1) << CTRL_TX_START;
            state_d = START;
         end
         START: state_d = SETTLE;
         SETTLE: begin
            re_d    = 1'b1;
            sel_d   = REG_STATUS;
            state_d = POLL;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_d   = 16'(TIMEOUT_CYCLES - 1);
`endif
         end
         POLL: begin
            if (!Data[STATUS_TX_BUSY]) begin
               ack_d[gnt_q] = 1'b1;
               state_d      = DONE;
            end else begin
`ifdef UART_SCHED_TIMEOUT_EN
               if (cnt_q == 16'd0) begin
                  terr_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 16'd1;
                  re_d  = 1'b1;
                  sel_d = REG_STATUS;
               end
`else
               re_d  = 1'b1;
               sel_d = REG_STATUS;
`endif
            end
         end
         DONE: begin
            rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         byte_q   <= '0;
         ack_q    <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         sel_q    <= REG_DATA;
         wdat_q   <= '0;
         terr_q   <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         byte_q   <= byte_d;
         ack_q    <= ack_d;
         we_q     <= we_d;
         re_q     <= re_d;
         sel_q    <= sel_d;
         wdat_q   <= wdat_d;
         terr_q   <= terr_d;
`ifdef UART_SCHED_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign ack         = ack_q;
   assign busy        = (state_q != IDLE);
   assign writeEnable = we_q;
   assign readEnable  = re_q;
   assign regSelect   = sel_q;
   assign writeData   = wdat_q;
   assign timeoutErr  = terr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a behavioural Uart model and
// a queue-based round-robin reference for randomized multi-requester traffic.
module tb_uart_tx_scheduler;

   localparam int NREQ = 4;
   localparam int TMO  = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] reqData;
   logic [NREQ-1:0]   ack;
   logic              busy;
   logic              writeEnable;
   logic              readEnable;
   logic [1:0]        regSelect;
   logic [7:0]        writeData;
   logic [7:0]        Data;
   logic              timeoutErr;

   int checks   = 0;
   int failures = 0;

   uart_tx_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .reqData     (reqData),
      .ack         (ack),
      .busy        (busy),
      .writeEnable (writeEnable),
      .readEnable  (readEnable),
      .regSelect   (regSelect),
      .writeData   (writeData),
      .Data        (Data),
      .timeoutErr  (timeoutErr)
   );

   always #5 clk = ~clk;

   // Uart model: txStart loads a shift countdown; txBusy reads 1 while it runs.
   int busy_cnt  = 0;
   int shift_len = 4;
   bit stuck     = 1'b0;

   always @(posedge clk) begin
      if (reset) busy_cnt <= 0;
      else if (writeEnable && regSelect == 2'b10 && writeData[0]) busy_cnt <= shift_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   assign Data = (regSelect == 2'b01) ? {7'b0, (busy_cnt != 0) || stuck} : 8'h00;

   // Observations of the most recent transfer
   bit              obs_got;
   logic [NREQ-1:0] obs_ack;
   int              obs_lat;
   int              obs_nwr;
   int              obs_poll;
   bit              obs_bad;
   logic [1:0]      obs_wr_reg [4];
   logic [7:0]      obs_wr_dat [4];

   // Runs from a negedge until an ack is seen or the budget expires; returns at the ack negedge.
   // mode 1: overwrite requester mod_idx's byte after LOAD; mode 2: drop its req after LOAD.
   task automatic xfer(input int mode, input int mod_idx, input logic [7:0] new_byte, input int budget);
      bit applied;
      applied  = 1'b0;
      obs_got  = 1'b0;
      obs_ack  = '0;
      obs_lat  = -1;
      obs_nwr  = 0;
      obs_poll = 0;
      obs_bad  = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (writeEnable && readEnable) obs_bad = 1'b1;
         if ($countones(ack) > 1) obs_bad = 1'b1;
         if (writeEnable) begin
            if (obs_lat < 0) obs_lat = c;
            if (obs_nwr < 4) begin
               obs_wr_reg[obs_nwr] = regSelect;
               obs_wr_dat[obs_nwr] = writeData;
            end
            obs_nwr++;
            if (regSelect == 2'b00 && !applied && mode != 0) begin
               applied = 1'b1;
               if (mode == 1) reqData[8*mod_idx +: 8] = new_byte;
               else req[mod_idx] = 1'b0;
            end
         end
         if (readEnable) obs_poll++;
         if (ack != '0) begin
            obs_got = 1'b1;
            obs_ack = ack;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      req     = '0;
      reqData = '0;
      stuck   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ack, busy, writeEnable, readEnable, regSelect, writeData, timeoutErr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ack=%b busy=%b we=%b re=%b sel=%b wd=%h terr=%b required all 0",
                  ack, busy, writeEnable, readEnable, regSelect, writeData, timeoutErr);
      end
   endtask

   task automatic test_single();
      do_reset();
      shift_len = 20;
      req = 4'b0001;
      reqData[7:0] = 8'hAA;
      xfer(0, 0, 8'h00, 200);
      req = '0;
      checks++;
      if (obs_lat !== 1) begin failures++; $display("FAIL single_latency: got %0d required 1", obs_lat); end
      checks++;
      if (obs_nwr !== 2 || obs_wr_reg[0] !== 2'b00 || obs_wr_dat[0] !== 8'hAA) begin
         failures++;
         $display("FAIL single_data_write: n=%0d reg=%b dat=%h required n=2 reg=00 dat=AA", obs_nwr, obs_wr_reg[0], obs_wr_dat[0]);
      end
      checks++;
      if (obs_wr_reg[1] !== 2'b10 || obs_wr_dat[1] !== 8'h01) begin
         failures++;
         $display("FAIL single_ctrl_write: reg=%b dat=%h required reg=10 dat=01", obs_wr_reg[1], obs_wr_dat[1]);
      end
      checks++;
      if (obs_poll !== 20) begin failures++; $display("FAIL single_poll_cycles: got %0d required 20", obs_poll); end
      checks++;
      if (!obs_got || obs_ack !== 4'b0001) begin
         failures++;
         $display("FAIL single_ack: got_ack=%0d ack=%b required 0001", obs_got, obs_ack);
      end
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_ack_once: ack=%b busy=%b required ack=0000 busy=0", ack, busy);
      end
   endtask

   task automatic test_contention();
      int exp_g;
      logic [7:0] exp_b;
      do_reset();
      req = 4'b1111;
      reqData = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int k = 0; k < 5; k++) begin
         shift_len = int'($urandom_range(2, 6));
         xfer(0, 0, 8'h00, 200);
         exp_g = k % 4;
         exp_b = 8'(8'h11 * (exp_g + 1));
         checks++;
         if (!obs_got || obs_ack !== 4'(1 << exp_g) || obs_wr_dat[0] !== exp_b) begin
            failures++;
            $display("FAIL contention_%0d: ack=%b data=%h required ack=%b data=%h", k, obs_ack, obs_wr_dat[0], 4'(1 << exp_g), exp_b);
         end
      end
      req = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      shift_len = 3;
      reqData = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      req = 4'b0100;
      xfer(0, 0, 8'h00, 200);
      checks++;
      if (obs_ack !== 4'b0100) begin failures++; $display("FAIL wrap_setup: ack=%b required 0100", obs_ack); end
      req = 4'b0101;
      xfer(0, 0, 8'h00, 200);
      checks++;
      if (obs_ack !== 4'b0001 || obs_wr_dat[0] !== 8'hA1) begin
         failures++;
         $display("FAIL wrap_first: ack=%b data=%h required ack=0001 data=A1", obs_ack, obs_wr_dat[0]);
      end
      xfer(0, 0, 8'h00, 200);
      checks++;
      if (obs_ack !== 4'b0100 || obs_wr_dat[0] !== 8'hC3) begin
         failures++;
         $display("FAIL wrap_second: ack=%b data=%h required ack=0100 data=C3", obs_ack, obs_wr_dat[0]);
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      bit seen_poll;
      bit early_ack;
      do_reset();
      shift_len = 30;
      reqData = {8'h04, 8'h03, 8'h02, 8'h01};
      req = 4'b0001;
      xfer(0, 0, 8'h00, 200);
      req = 4'b0011;
      seen_poll = 1'b0;
      early_ack = 1'b0;
      for (int c = 0; c < 40 && !seen_poll; c++) begin
         @(negedge clk);
         if (ack != '0) early_ack = 1'b1;
         if (readEnable) seen_poll = 1'b1;
      end
      checks++;
      if (!seen_poll || early_ack) begin
         failures++;
         $display("FAIL reset_mid_reach_poll: poll=%0d early_ack=%0d required poll=1 early_ack=0", seen_poll, early_ack);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ack, busy, writeEnable, readEnable, regSelect, writeData} !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs: ack=%b busy=%b we=%b re=%b sel=%b wd=%h required all 0",
                  ack, busy, writeEnable, readEnable, regSelect, writeData);
      end
      @(negedge clk);
      reset = 1'b0;
      shift_len = 3;
      xfer(0, 0, 8'h00, 200);
      checks++;
      if (obs_ack !== 4'b0001 || obs_wr_dat[0] !== 8'h01) begin
         failures++;
         $display("FAIL reset_mid_rearb: ack=%b data=%h required ack=0001 data=01", obs_ack, obs_wr_dat[0]);
      end
      req = '0;
   endtask

   task automatic test_data_stable();
      do_reset();
      shift_len = 8;
      req = 4'b0001;
      reqData[7:0] = 8'h3C;
      xfer(1, 0, 8'h55, 200);
      req = '0;
      checks++;
      if (!obs_got || obs_ack !== 4'b0001 || obs_nwr !== 2 || obs_wr_dat[0] !== 8'h3C || obs_wr_reg[1] !== 2'b10) begin
         failures++;
         $display("FAIL data_stable: ack=%b n_writes=%0d data=%h reg1=%b required ack=0001 n_writes=2 data=3C reg1=10",
                  obs_ack, obs_nwr, obs_wr_dat[0], obs_wr_reg[1]);
      end
   endtask

   task automatic test_random();
      int n [4];
      int head [4];
      logic [7:0] bq [4][4];
      int ptr;
      int remaining;
      int g;
      int idx;
      int mode;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         remaining = 0;
         for (int i = 0; i < 4; i++) begin
            n[i] = int'($urandom_range(0, 3));
            head[i] = 0;
            for (int k = 0; k < 4; k++) bq[i][k] = 8'($urandom);
         end
         if (n[0] + n[1] + n[2] + n[3] == 0) n[$urandom_range(0, 3)] = 2;
         for (int i = 0; i < 4; i++) remaining += n[i];
         ptr = 0;
         for (int i = 0; i < 4; i++) begin
            req[i] = (head[i] < n[i]);
            reqData[8*i +: 8] = (head[i] < n[i]) ? bq[i][head[i]] : 8'h00;
         end
         while (remaining > 0) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
               idx = (ptr + k) % 4;
               if (g < 0 && head[idx] < n[idx]) g = idx;
            end
            shift_len = int'($urandom_range(2, 10));
            mode = int'($urandom_range(0, 2));
            if (mode == 2 && head[g] != n[g] - 1) mode = 0;
            xfer(mode, g, ~bq[g][head[g]], 300);
            checks++;
            if (!obs_got || obs_ack !== 4'(1 << g) || obs_wr_dat[0] !== bq[g][head[g]] || obs_bad) begin
               failures++;
               $display("FAIL random_r%0d: got=%0d ack=%b data=%h bad=%0d required ack=%b data=%h bad=0",
                        r, obs_got, obs_ack, obs_wr_dat[0], obs_bad, 4'(1 << g), bq[g][head[g]]);
            end
            head[g]++;
            ptr = (g + 1) % 4;
            remaining--;
            for (int i = 0; i < 4; i++) begin
               req[i] = (head[i] < n[i]);
               reqData[8*i +: 8] = (head[i] < n[i]) ? bq[i][head[i]] : 8'h00;
            end
         end
      end
      req = '0;
   endtask

`ifdef UART_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int polls;
      bit any_ack;
      bit hit;
      do_reset();
      stuck = 1'b1;
      reqData = {8'h00, 8'h00, 8'h77, 8'h66};
      req = 4'b0001;
      polls = 0;
      any_ack = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < TMO + 40 && !hit; c++) begin
         @(negedge clk);
         if (readEnable) polls++;
         if (ack != '0) any_ack = 1'b1;
         if (timeoutErr) hit = 1'b1;
      end
      checks++;
      if (!hit || any_ack || polls !== TMO) begin
         failures++;
         $display("FAIL timeout_abort: terr=%0d ack_seen=%0d polls=%0d required terr=1 ack_seen=0 polls=%0d", hit, any_ack, polls, TMO);
      end
      stuck = 1'b0;
      shift_len = 3;
      req = 4'b0011;
      xfer(0, 0, 8'h00, 200);
      req = '0;
      checks++;
      if (obs_ack !== 4'b0010 || obs_wr_dat[0] !== 8'h77 || timeoutErr !== 1'b1) begin
         failures++;
         $display("FAIL timeout_next: ack=%b data=%h terr=%b required ack=0010 data=77 terr=1", obs_ack, obs_wr_dat[0], timeoutErr);
      end
   endtask
`endif

   initial begin
      reset   = 1'b1;
      req     = '0;
      reqData = '0;
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_reset_mid();
      test_data_stable();
      test_random();
`ifdef UART_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
